dpram_clr: RTL
==============

// Module: dpram_clr
// PURPOSE
//  Parametrised simple dual-port RAM (one write port, one read port, one clock)
//  with byte write enables, selectable read latency, selectable read-during-write
//  mode and a hardware clear engine that zero-fills the array after reset or on request.
//  It is the next-generation general-purpose storage block for register files, FIFOs and scratch memories.
// PARAMETERS
//  ADDR_WIDTH   4    address bits on both ports
//  DATA_WIDTH   8    word width; must be a multiple of BYTE_WIDTH, otherwise elaboration error
//  DATA_DEPTH   16   number of words; DATA_DEPTH <= 2**ADDR_WIDTH
//  BYTE_WIDTH   8    lane width covered by one wr_be bit; NB = DATA_WIDTH/BYTE_WIDTH
//  RD_LATENCY   1    1 = registered read; 2 = extra output register
//  RDW_MODE     0    same-address read/write in one cycle: 0 = old data, 1 = new (merged) data
//  CLEAR_VALUE  0    word written to every location by the clear engine
// PORTS
//  clk      in   1            clock, all state on rising edge
//  rst_n    in   1            reset, asynchronous, active-low
//  en       in   1            port enable; 0 = user reads/writes ignored
//  wr_en    in   1            write strobe
//  wr_be    in   NB           per-lane write enable
//  wr_addr  in   ADDR_WIDTH   write address
//  wr_data  in   DATA_WIDTH   write data
//  rd_en    in   1            read strobe
//  rd_addr  in   ADDR_WIDTH   read address
//  rd_data  out  DATA_WIDTH   read data, holds last value between reads
//  rd_valid out  1            one-cycle pulse when rd_data carries a new read result
//  clr_req  in   1            request full-array clear (sampled in IDLE only)
//  busy     out  1            clear engine running; user ops dropped
// BEHAVIOUR
//  - Reset (rst_n low, async): rd_data=0, rd_valid=0, read pipeline flushed, busy=1, FSM=CLEAR, clr_ptr=0.
//    Array contents are not reset directly; they are cleared by the sweep after release.
//  - FSM IDLE/CLEAR. CLEAR: each edge writes CLEAR_VALUE to mem[clr_ptr], clr_ptr++; at clr_ptr==DATA_DEPTH-1
//    write last word, go IDLE. busy=1 for exactly DATA_DEPTH cycles. Sweep runs regardless of en.
//  - IDLE: clr_req=1 at edge -> CLEAR, clr_ptr=0, busy=1 from next cycle. clr_req while busy ignored.
//  - Write: en&wr_en&!busy at edge: for each lane b with wr_be[b]=1, mem[wr_addr][b] <= wr_data[b];
//    other lanes unchanged. wr_be=0 is a no-op. wr_addr >= DATA_DEPTH: write dropped.
//  - Read: en&rd_en&!busy at edge N. RD_LATENCY=1: rd_data updated at edge N, rd_valid=1 during
//    cycle N..N+1. RD_LATENCY=2: updated at edge N+1. Fully pipelined, one read per cycle.
//    rd_addr >= DATA_DEPTH: rd_data=0, rd_valid still pulses.
//  - Collision (read and write same address, same edge): RDW_MODE=0 returns pre-write word;
//    RDW_MODE=1 returns merged word (enabled lanes from wr_data, others old).
//  - Clear start with a read in flight (RD_LATENCY=2): in-flight read completes with pre-clear data.
//  - Reset mid-clear: sweep restarts from address 0, full DATA_DEPTH cycles again.
// TESTING
//  Build configs: (A) defaults; (B) DATA_WIDTH=16, RD_LATENCY=2, RDW_MODE=1.
//  1 Release rst_n -> busy high exactly 16 cycles; then read addr 0..15 -> rd_data=0x00, rd_valid pulse each.
//  2 (A) write addr i = 0xAA/0x55 alternating, read addr i-1 same cycle -> next cycle rd_data = value of i-1.
//  3 (B) fill 0xAAAA; write addr 3 data 0x0055 wr_be=2'b01 -> read addr 3 returns 0xAA55 two edges later.
//  4 mem[5]=0x12 (A) / 0x1234 (B); write 5 = 0xAB/0xABCD be all-ones with read 5 same edge ->
//    A returns 0x12, B returns 0xABCD; subsequent read returns new value in both.
//  5 After fill, pulse clr_req -> busy 16 cycles; writes during busy dropped; all reads then 0.
//    Repeat with rst_n pulsed at clr_ptr=7 -> busy 16 further cycles after release.
//  6 Reads with en=0 or addr 16+ (ADDR_WIDTH=5 build) -> no rd_valid / rd_data=0 with rd_valid.

Source files
------------

// File: rtl/dpram_clr.sv
// dpram_clr: simple dual-port RAM with one write port, one read port and one clock.
// It has byte-lane write enables, a read latency of 1 or 2 cycles and a selectable
// read-during-write result. A clear engine zero-fills (CLEAR_VALUE-fills) the
// array after reset or on request, and user traffic is dropped while it runs.
module dpram_clr #(
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DATA_DEPTH  = 16,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    RD_LATENCY  = 1,
  parameter int                    RDW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               wr_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  input  logic                               clr_req,
  output logic                               busy
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  // Reject configurations that cannot be built correctly
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lane_width
    $error("dpram_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("dpram_clr: RD_LATENCY must be 1 or 2");
  end
  if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("dpram_clr: DATA_DEPTH exceeds the address space");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word;

  // Qualify user requests and form the word a read returns, including the collision merge
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    wr_fire     = en & wr_en & ~busy & wr_in_range;
    rd_fire     = en & rd_en & ~busy;
    old_word    = rd_in_range ? mem[rd_addr] : '0;
    rd_word     = old_word;
    if (RDW_MODE != 0 && wr_fire && (wr_addr == rd_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Clear engine: sweeps every address once, restarting from zero on reset or request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_ptr == LAST_PTR) begin
            state   <= IDLE;
            clr_ptr <= '0;
            busy    <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Array storage: the sweep owns the write port while clearing, otherwise lane-masked user writes
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= CLEAR_VALUE;
    end else if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_rd_lat2
    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    // Two-stage read: the first stage captures the word, so a clear starting behind it cannot corrupt it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_valid <= 1'b0;
        pipe_data  <= '0;
        rd_valid   <= 1'b0;
        rd_data    <= '0;
      end else begin
        pipe_valid <= rd_fire;
        if (rd_fire) begin
          pipe_data <= rd_word;
        end
        rd_valid <= pipe_valid;
        if (pipe_valid) begin
          rd_data <= pipe_data;
        end
      end
    end
  end else begin : g_rd_lat1
    // Single-stage read: result lands on the same edge that accepts the request
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        rd_valid <= rd_fire;
        if (rd_fire) begin
          rd_data <= rd_word;
        end
      end
    end
  end

endmodule
